// File: rtl/seven_seg_display_driver_pkg.sv
// Shared types and constants for the seven-segment display driver:
// converter FSM encoding, segment patterns and digit-count constants.
package seven_seg_display_driver_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_LOAD  = 2'd2
  } conv_state_e;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int BIN_W      = 9;
  localparam int CONV_ITERS = 9;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // BCD nibble to active-low segment pattern; non-decimal nibbles go dark
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

  // Double-dabble correction: a nibble of 5 or more gets +3 before the shift
  function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
    logic [3:0] res;
    if (nibble >= 4'd5) begin
      res = nibble + 4'd3;
    end else begin
      res = nibble;
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_display_driver_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. One conversion takes
// one capture cycle, nine shift cycles and one load cycle; done_o is high
// during the load cycle, when bcd_o holds the finished result.
module bin2bcd_seq
  import seven_seg_display_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] value_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam logic [3:0] ITER_LAST = 4'(CONV_ITERS - 1);

  conv_state_e      state_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [3:0]       iter_q;
  logic             busy_q;
  logic             done_q;

  logic [BCD_W-1:0]       adj_s;
  logic [BCD_W+BIN_W-1:0] shift_s;

  // One double-dabble step: correct every nibble, then shift {bcd, bin} left
  always_comb begin
    adj_s   = {bcd_adjust(bcd_q[11:8]), bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};
    shift_s = {adj_s, bin_q} << 1;
  end

  // Conversion FSM with registered busy/done flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CONV_IDLE: begin
          if (start_i) begin
            bin_q   <= value_i;
            bcd_q   <= '0;
            iter_q  <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          bcd_q  <= shift_s[BCD_W+BIN_W-1:BIN_W];
          bin_q  <= shift_s[BIN_W-1:0];
          iter_q <= iter_q + 4'd1;
          if (iter_q == ITER_LAST) begin
            done_q  <= 1'b1;
            state_q <= CONV_LOAD;
          end
        end
        CONV_LOAD: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= CONV_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= CONV_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seven_seg_display_driver.sv
// Shows a 9-bit value in decimal on a 4-digit multiplexed common-anode
// seven-segment display. A new conversion starts whenever the input
// differs from the last converted value and the converter is idle; the
// displayed digits only ever change atomically at the end of a conversion.
module seven_seg_display_driver
  import seven_seg_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int WIDTH       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             blank,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [WIDTH-1:0] shadow_q;
  logic [BCD_W-1:0] digits_q;
  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       idx_q;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             dp_q;

  logic             start_s;
  logic             conv_busy_s;
  logic             conv_done_s;
  logic [BCD_W-1:0] conv_bcd_s;
  logic [3:0]       nibble_s;
  logic             lit_s;

  // Only start when idle; changes during a conversion are picked up afterwards
  assign start_s = (value != shadow_q) && !conv_busy_s;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_s),
    .value_i (value),
    .busy_o  (conv_busy_s),
    .done_o  (conv_done_s),
    .bcd_o   (conv_bcd_s)
  );

  // Remember the value handed to the converter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else if (start_s) begin
      shadow_q <= value;
    end
  end

  // Displayed digits update in one step when the converter finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
    end else if (conv_done_s) begin
      digits_q <= conv_bcd_s;
    end
  end

  // Refresh divider and digit scan index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
    end else if (refresh_q == CNT_LAST) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
    end
  end

  // Digit select with leading-zero suppression and global blanking
  always_comb begin
    nibble_s = 4'd0;
    lit_s    = 1'b0;
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    case (idx_q)
      2'd0: begin
        nibble_s = digits_q[3:0];
        lit_s    = 1'b1;
      end
      2'd1: begin
        nibble_s = digits_q[7:4];
        lit_s    = (digits_q[11:8] != 4'd0) || (digits_q[7:4] != 4'd0);
      end
      2'd2: begin
        nibble_s = digits_q[11:8];
        lit_s    = (digits_q[11:8] != 4'd0);
      end
      default: begin
        nibble_s = 4'd0;
        lit_s    = 1'b0;
      end
    endcase
    if (blank || !lit_s) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_decode(nibble_s);
    end
  end

  // Output registers, loaded every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= 1'b1;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign busy = conv_busy_s;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Self-checking bench for seven_seg_display_driver with REFRESH_DIV=4.
// Expected displayed values are queued when a value is driven and popped
// when a conversion ends; a per-cycle monitor compares the scan outputs
// against a model of the refresh index, the expected digits and blanking.
module tb_seven_seg_display_driver;

  localparam int DIV = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [8:0] value = 9'd0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  seven_seg_display_driver #(.REFRESH_DIV(DIV), .WIDTH(9)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .blank (blank),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned sb_q[$];
  int unsigned disp_m   = 0;
  int unsigned cnt_m    = 0;
  int unsigned idx_m    = 0;
  int unsigned busy_run = 0;
  int unsigned n_conv   = 0;
  logic        blank_prev = 1'b0;
  logic        busy_prev  = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {an, seg} for a scan index, displayed decimal value and blank
  function automatic logic [10:0] exp_out(input int unsigned idx, input int unsigned v, input logic blk);
    int unsigned h, t, u, nib;
    logic        lit;
    logic [3:0]  one_hot;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (idx)
      0:       begin lit = 1'b1;               nib = u; end
      1:       begin lit = (h != 0) || (t != 0); nib = t; end
      2:       begin lit = (h != 0);           nib = h; end
      default: begin lit = 1'b0;               nib = 0; end
    endcase
    if (blk || !lit) return {4'hF, 7'h7F};
    one_hot = 4'b0001 << idx;
    return {~one_hot, seg_tab[nib]};
  endfunction

  // Per-cycle monitor, sampling on the falling edge
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      check_eq("rst_seg", seg, 7'h7F);
      check_eq("rst_an", an, 4'hF);
      check_eq("rst_dp", dp, 1);
      check_eq("rst_busy", busy, 0);
      cnt_m      = 0;
      idx_m      = 0;
      disp_m     = 0;
      busy_run   = 0;
      busy_prev  = 1'b0;
      blank_prev = blank;
    end else begin
      e = exp_out(idx_m, disp_m, blank_prev);
      check_eq($sformatf("an_idx%0d_v%0d", idx_m, disp_m), an, e[10:7]);
      check_eq($sformatf("seg_idx%0d_v%0d", idx_m, disp_m), seg, e[6:0]);
      check_eq("dp", dp, 1);
      if (busy) begin
        busy_run++;
      end else if (busy_prev) begin
        n_conv++;
        check_eq("busy_len", busy_run, 10);
        check_eq("sb_has_entry", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) disp_m = sb_q.pop_front();
        busy_run = 0;
      end
      if (cnt_m == DIV - 1) begin
        cnt_m = 0;
        idx_m = (idx_m + 1) % 4;
      end else begin
        cnt_m++;
      end
      blank_prev = blank;
      busy_prev  = busy;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned v, input bit expect_conv);
    @(posedge clk);
    #1;
    value = 9'(v);
    if (expect_conv) sb_q.push_back(v);
  endtask

  task automatic wait_quiet(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && busy == 1'b0) break;
    end
    check_eq("quiet_in_time", (sb_q.size() == 0 && busy == 1'b0), 1);
  endtask

  int unsigned vals[3] = '{7, 70, 105};
  int unsigned base;

  initial begin
    // Reset with value=0, then idle scanning with no conversion
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_cycles(40);
    check_eq("no_conv_at_zero", n_conv, 0);

    // Full-scale value
    drive(511, 1'b1);
    wait_quiet(60);
    wait_cycles(20);

    // Leading-zero suppression cases
    for (int k = 0; k < 3; k++) begin
      drive(vals[k], 1'b1);
      wait_quiet(60);
      wait_cycles(20);
    end

    // Changes while busy: only the last stable value is converted
    base = n_conv;
    drive(200, 1'b1);
    wait_cycles(3);
    drive(300, 1'b0);
    wait_cycles(3);
    drive(400, 1'b1);
    wait_quiet(80);
    wait_cycles(20);
    check_eq("conv_count_200_400", n_conv - base, 2);

    // Blanking for 20 cycles
    @(posedge clk);
    #1 blank = 1'b1;
    wait_cycles(20);
    blank = 1'b0;
    wait_cycles(20);

    // Reset in the middle of converting 256, then restart
    drive(256, 1'b1);
    wait_cycles(5);
    check_eq("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("abort_seg", seg, 7'h7F);
    check_eq("abort_an", an, 4'hF);
    check_eq("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_quiet(60);
    wait_cycles(20);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_display_driver.md
Name: seven_seg_display_driver

Overview:
Output-side companion to the push-button counter. It takes the 9-bit counter value (0..511) and shows it in decimal on a 4-digit, time-multiplexed, common-anode seven-segment display. A sequential shift-add-3 (double-dabble) converter turns the binary value into BCD. A refresh divider scans the digits.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays lit; legal range ≥2; benches use 4.
WIDTH, 9, binary input width; fixed at 9 for this block (3 BCD digits).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
value  input  9  unsigned binary value to display
blank  input  1  1 = all digits off (an=4'b1111); scan and conversion keep running
seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
dp  output  1  decimal point, active-low; held 1 (off)
an  output  4  digit anodes, active-low; an[0] = units
busy  output  1  high while a conversion is in progress

Behaviour:
- Reset values:
  - Outputs: seg=7'h7F, dp=1, an=4'b1111, busy=0.
  - Internal state: refresh count=0, digit index=0, shadow value=0, displayed BCD digits=0, FSM=IDLE.
- Conversion FSM has states IDLE, SHIFT and LOAD.
  - IDLE: if value != shadow, then capture value into the binary shift register, set shadow<=value, clear the BCD register and the iteration count, and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After exactly 9 iterations, go to LOAD.
  - LOAD: copy hundreds/tens/units into the displayed-digit registers atomically, then go to IDLE with busy=0.
  - Latency: a value sampled at edge N appears in the displayed digits after edge N+10; busy is high for edges N+1..N+10.
- Changes on value while busy are ignored. On return to IDLE the value is compared again, and a new conversion starts if it differs from shadow. Only the last stable value matters; no queue.
- The displayed digits never show a partially converted result.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Output registers load every cycle from the current index and digits (1-cycle latency):
  - idx0 shows units; it is always lit, so 0 displays as "0".
  - idx1 shows tens; it is blanked if hundreds=0 and tens=0.
  - idx2 shows hundreds; it is blanked if hundreds=0.
  - idx3 is always blanked.
  - Blanked digit: an bit high, seg=7'h7F.
  - Exactly one an bit is low when the digit is not blanked and blank=0.
- Segment decode (active-low, {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibble >9 cannot occur; if it does, decode to 7'h7F.
- blank=1 forces an=4'b1111 and seg=7'h7F on the next edge. The index and the converter are unaffected.
- Reset mid-conversion: abort immediately and return to reset values. A nonzero value then triggers a fresh conversion on the first edge after rst deasserts.

Decomposition:
- Shared package contains:
  - FSM state encoding (IDLE/SHIFT/LOAD).
  - The 10-entry active-low segment pattern constants plus SEG_OFF=7'h7F.
  - AN_OFF=4'b1111.
  - BCD_DIGITS=3 and the iteration count 9.
- One sub-module, bin2bcd_seq, contains the FSM, shift register and busy logic. It has a start/value/done/bcd interface.
- The top module holds the change detect, refresh divider, digit mux, blanking and output registers.

Test Plan:
- Reset, value=0, REFRESH_DIV=4 → all outputs at reset values during rst. After release, no conversion (busy stays 0); an cycles 1110 with seg=40, and 1101/1011/0111 positions are blanked (an=1111, seg=7F), each lasting 4 cycles.
- value 0→511 at edge N → busy high for edges N+1..N+10; from then on the digits read 5,1,1: idx2 seg=12, idx1 seg=79, idx0 seg=79.
- value=7 then 70 then 105 (each held until busy=0) → 7 shows only idx0 lit (seg=78). 70 shows idx1=78 and idx0=40. 105 shows 79/40/12 on idx2/1/0, and the tens zero is displayed.
- value changes 200→300→400 while busy → display never shows 300. Final digits are 4,0,0, and exactly one extra conversion follows the first.
- blank=1 for 20 cycles → an=1111, seg=7F throughout. On release, the scan resumes at the index it has advanced to and the digits are unchanged.
- rst pulsed at SHIFT iteration 5 of converting 256 → outputs return to reset values. After release, a conversion restarts and displays 2,5,6 ten cycles later.
